// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - multi-channel pulse width meter with round-robin result merge
module pulse_width_meter #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int MIN_WIDTH   = 1,
    localparam int PW         = $clog2(CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_ch,
    output logic [CNT_W-1:0] out_width,
    output logic             out_sat,
    output logic [CH-1:0]    ovf_flag,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);

    // Synchroniser chain: stage 0 samples the raw pins, the last stage is the usable level
    logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
    logic [CH-1:0]                  lvl_d1_q, lvl_d1_d;
    logic [CH-1:0]                  level, rise, fall;

    // Per-channel width counters and saturation marks
    logic [CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [CH-1:0]                  sat_q, sat_d;

    // Per-channel single-entry hold buffers between measurement and arbiter
    logic [CH-1:0][CNT_W-1:0]       hold_width_q, hold_width_d;
    logic [CH-1:0]                  hold_sat_q, hold_sat_d;
    logic [CH-1:0]                  hold_valid_q, hold_valid_d;
    logic [CH-1:0]                  ovf_q, ovf_d;

    // Arbiter pointer (last granted channel) and output register
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic                           out_valid_q, out_valid_d;
    logic [PW-1:0]                  out_ch_q, out_ch_d;
    logic [CNT_W-1:0]               out_width_q, out_width_d;
    logic                           out_sat_q, out_sat_d;

    logic                           out_free;
    logic                           grant_any;
    logic [PW-1:0]                  grant_ch;
    logic [CH-1:0]                  grant;

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~lvl_d1_q;
    assign fall  = ~level & lvl_d1_q;

    // Shift every channel's synchroniser by one stage and remember the previous level
    always_comb begin
        sync_d[0] = data_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        lvl_d1_d = level;
    end

    // Round-robin search for the first pending hold after the last granted channel
    always_comb begin
        int idx;
        idx       = 0;
        out_free  = ~out_valid_q | out_ready;
        grant_any = 1'b0;
        grant_ch  = '0;
        grant     = '0;
        if (out_free) begin
            for (int i = 1; i <= CH; i++) begin
                idx = (int'(ptr_q) + i) % CH;
                if (!grant_any && hold_valid_q[idx]) begin
                    grant_any = 1'b1;
                    grant_ch  = PW'(idx);
                end
            end
        end
        if (grant_any) begin
            grant[grant_ch] = 1'b1;
        end
    end

    // Count high time, then capture or drop the finished measurement at the falling edge
    always_comb begin
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        hold_width_d = hold_width_q;
        hold_sat_d   = hold_sat_q;
        hold_valid_d = hold_valid_q;
        ovf_d        = ovf_clr ? '0 : ovf_q;
        for (int c = 0; c < CH; c++) begin
            if (rise[c]) begin
                cnt_d[c] = CNT_W'(1);
                sat_d[c] = 1'b0;
            end else if (level[c]) begin
                if (cnt_q[c] != CNT_MAX) begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end else begin
                    sat_d[c] = 1'b1;
                end
            end

            // A grant empties the hold; a same-cycle capture refills it without loss
            if (grant[c]) begin
                hold_valid_d[c] = 1'b0;
            end
            if (fall[c] && (cnt_q[c] >= MIN_W)) begin
                if (!hold_valid_q[c] || grant[c]) begin
                    hold_width_d[c] = cnt_q[c];
                    hold_sat_d[c]   = sat_q[c];
                    hold_valid_d[c] = 1'b1;
                end else begin
                    // New overflow beats a simultaneous clear
                    ovf_d[c] = 1'b1;
                end
            end
        end
    end

    // Load the output register from the granted hold, or go idle when nothing is pending
    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_width_d = out_width_q;
        out_sat_d   = out_sat_q;
        ptr_d       = ptr_q;
        if (out_free) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                out_ch_d    = grant_ch;
                out_width_d = hold_width_q[grant_ch];
                out_sat_d   = hold_sat_q[grant_ch];
                ptr_d       = grant_ch;
            end
        end
    end

    // State registers; pointer resets to the last channel so channel 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            lvl_d1_q     <= '0;
            cnt_q        <= '0;
            sat_q        <= '0;
            hold_width_q <= '0;
            hold_sat_q   <= '0;
            hold_valid_q <= '0;
            ovf_q        <= '0;
            ptr_q        <= PW'(CH - 1);
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_width_q  <= '0;
            out_sat_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            lvl_d1_q     <= lvl_d1_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            hold_width_q <= hold_width_d;
            hold_sat_q   <= hold_sat_d;
            hold_valid_q <= hold_valid_d;
            ovf_q        <= ovf_d;
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_width_q  <= out_width_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_width = out_width_q;
    assign out_sat   = out_sat_q;
    assign ovf_flag  = ovf_q;

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Multi-channel pulse-width measurement block for the pulse-handling subsystem. Each of CH asynchronous level inputs is synchronised, edge-detected and timed in `clk` cycles. Completed measurements above a glitch threshold are buffered per channel and merged round-robin onto one valid/ready result port. Per-channel sticky overflow flags report lost measurements.

## Interface
- CH, 4: number of input channels (≥2)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- CNT_W, 8: width counter bits; max reportable width 2^CNT_W−1
- MIN_WIDTH, 1: pulses with measured width < MIN_WIDTH are discarded silently (1 ≤ MIN_WIDTH ≤ 2^CNT_W−1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- data_in  in  CH  asynchronous pulse inputs, active high
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result when out_valid & out_ready at a rising edge
- out_ch  out  $clog2(CH)  channel index of result
- out_width  out  CNT_W  measured high time in clk cycles
- out_sat  out  1  width counter saturated; out_width = 2^CNT_W−1
- ovf_flag  out  CH  sticky: measurement dropped on that channel
- ovf_clr  in  1  synchronous clear of all ovf_flag bits

## Operation
- Reset: all sync flops, edge regs, counters, hold regs, output reg cleared; out_valid=0, out_ch=0, out_width=0, out_sat=0, ovf_flag=0; round-robin pointer = CH−1 (channel 0 has first priority).
- Per channel: sync chain s[0..S−1]; level = s[S−1]; d = level delayed one cycle. rise = level & ~d, fall = ~level & d.
- Counter: on rise, cnt ← 1, sat ← 0. While level & ~rise: cnt ← cnt+1 if cnt < max, else hold at max and sat ← 1.
- On fall: if cnt ≥ MIN_WIDTH, the measurement is captured into the channel hold reg {cnt, sat}, hold_valid ← 1. If hold_valid is already 1 and not granted in the same cycle, the new measurement is dropped and ovf_flag[ch] ← 1. Below-threshold pulses neither capture nor set overflow.
- Output stage: the output reg is "free" when ~out_valid or (out_valid & out_ready). When free, the arbiter grants the first channel with hold_valid, searching from pointer+1 mod CH upward. On grant: output reg ← {ch, width, sat}, out_valid ← 1, hold_valid[ch] ← 0, pointer ← ch. With no pending channel and the output reg free, out_valid ← 0.
- Grant and a fall on the same channel in the same cycle: the old hold moves out and the new measurement is captured. No overflow.
- Output reg is stable while out_valid & ~out_ready.
- ovf_clr clears all flags. A simultaneous new overflow on a channel sets that bit (set wins).
- If data_in is high when reset releases, a rise is detected once the level synchronises, and the pulse is measured from that cycle.

## Timing
- Input pulse sampled high at edges T1..T0−1 and low at T0: width W = T0−T1.
- Hold captured at edge T0+SYNC_STAGES. With the output free, out_valid is asserted after edge T0+SYNC_STAGES+1.
- Accepted results: at most one per cycle. Full throughput with out_ready held high.
- Minimum low gap between measurable pulses on a channel: 1 cycle. Consecutive pulses yield independent widths.
- When k channels are pending, each result leaves within k cycles of reaching the arbiter, given out_ready=1.

## Test plan
- Single pulse: ch2 high 5 cycles, out_ready=1 -> out_valid one cycle, out_ch=2, out_width=5, out_sat=0, 3 edges (SYNC_STAGES=2) after first low sample.
- Saturation: CNT_W=4, ch0 high 40 cycles -> out_width=15, out_sat=1. A following 3-cycle pulse -> width 3, sat 0.
- Glitch filter: MIN_WIDTH=3, pulses of 1 and 2 cycles on ch1 -> no output, ovf_flag=0. A 3-cycle pulse -> width 3.
- Round-robin: simultaneous 4-cycle pulses on all 4 channels, out_ready=1 -> out_ch sequence 0,1,2,3 on consecutive cycles. Next burst after a last grant of ch1 -> order 2,3,0,1.
- Backpressure/overflow: out_ready=0, three pulses on ch3 -> the first pulse sits in the output reg, the second in the hold reg, the third is dropped with ovf_flag[3]=1. Releasing out_ready -> widths 1st then 2nd. ovf_clr -> flag 0.
- Reset mid-pulse: assert rst_n low during a ch0 pulse -> all outputs 0 immediately. After release with data_in low, no spurious result.
